data_bus_responder: RTL and testbench

- Target side of the processor's data-memory bus: answers load strobes and byte-masked store writes.
- Contains the data RAM and a memory-mapped IO page with an LED register and an 8N1 UART transmitter.
- Sits beside the processor core in the SoC top level, fed directly by ramAddr/ramRStrb/memWData/memWMask.
- Returns ramRData one cycle after the strobe, matching the core's EXECUTE -> WAIT_DATA sequence; no wait states.

---
 rtl/data_bus_responder_pkg.sv | 12 +
 rtl/data_bus_responder_if.sv | 10 +
 rtl/data_bus_responder_uart_tx.sv | 66 ++++++
 rtl/data_bus_responder.sv | 50 +++++
 tb/tb_data_bus_responder.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/data_bus_responder_pkg.sv
// soc_pkg: shared IO map constants and UART state encoding for the data bus responder.
package soc_pkg;
  localparam int IO_PAGE_BIT = 22;
  localparam int IO_LEDS_BIT = 0;
  localparam int IO_UART_DATA_BIT = 1;
  localparam int IO_UART_CNTL_BIT = 2;
  localparam int UART_BUSY_BIT = 9;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [2:0] io_sel(input int b);
    return 3'(1 << b);
  endfunction
endpackage

// File: rtl/data_bus_responder_if.sv
// data_bus_responder_if: core-to-memory data bus (address, strobes, store data, read data).
interface data_bus_responder_if;
  logic [31:0] ramAddr;
  logic        ramRStrb;
  logic [31:0] memWData;
  logic [3:0]  memWMask;
  logic [31:0] ramRData;
  modport master (output ramAddr, ramRStrb, memWData, memWMask, input ramRData);
  modport slave (input ramAddr, ramRStrb, memWData, memWMask, output ramRData);
endinterface

// File: rtl/data_bus_responder_uart_tx.sv
// uart_tx: 8N1 LSB-first transmitter, DIV clocks per bit; writes while busy are ignored.
module uart_tx
  import soc_pkg::*;
#(
  parameter int DIV = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       busy
);
  localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
  uart_state_t state;
  logic [CW-1:0] cnt;
  logic [2:0] idx;
  logic [7:0] sh;
  logic last;
  assign last = cnt == CW'(DIV - 1);
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      tx <= 1'b1;
    end else begin
      cnt <= (state == IDLE || last) ? '0 : cnt + 1'b1;
      case (state)
        IDLE:
          if (start) begin
            state <= START;
            sh <= data;
            tx <= 1'b0;
          end
        START:
          if (last) begin
            state <= DATA;
            idx <= '0;
            tx <= sh[0];
          end
        DATA:
          if (last) begin
            if (idx == 3'd7) begin
              state <= STOP;
              tx <= 1'b1;
            end else begin
              idx <= idx + 3'd1;
              tx <= sh[idx + 3'd1];
            end
          end
        STOP:
          // a write landing on the final stop-bit edge chains straight into the next frame
          if (last) begin
            if (start) begin
              state <= START;
              sh <= data;
              tx <= 1'b0;
            end else state <= IDLE;
          end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: data RAM plus IO page (LEDs, UART) answering core loads/stores with one-cycle read latency.
module data_bus_responder
  import soc_pkg::*;
#(
  parameter int    RAM_WORDS = 16384,
  parameter string RAM_INIT  = "",
  parameter int    CLK_FREQ  = 50000000,
  parameter int    BAUD      = 115200,
  parameter int    NUM_LEDS  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  data_bus_responder_if.slave  bus,
  output logic [NUM_LEDS-1:0]  leds,
  output logic                 uartTx
);
  localparam int AW = $clog2(RAM_WORDS);
  localparam int DIV = CLK_FREQ / BAUD;
  logic [31:0] mem [RAM_WORDS];
  logic [AW-1:0] idx;
  logic [2:0] sel;
  logic [31:0] io_val;
  logic io, we, busy, unused;
  assign io = bus.ramAddr[IO_PAGE_BIT];
  assign idx = bus.ramAddr[AW+1:2];
  assign sel = bus.ramAddr[4:2];
  assign we = |bus.memWMask;
  assign unused = ^bus.ramAddr;
  always_comb
    io_val = sel == io_sel(IO_LEDS_BIT) ? 32'(leds) :
             sel == io_sel(IO_UART_CNTL_BIT) ? 32'(busy) << UART_BUSY_BIT : '0;
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we && !io && bus.memWMask[i]) mem[idx][8*i +: 8] <= bus.memWData[8*i +: 8];
  // nonblocking read of mem gives read-before-write on a same-cycle collision
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.ramRData <= '0;
    else if (bus.ramRStrb) bus.ramRData <= io ? io_val : mem[idx];
  always_ff @(posedge clk or posedge reset)
    if (reset) leds <= '0;
    else if (we && io && sel == io_sel(IO_LEDS_BIT)) leds <= bus.memWData[NUM_LEDS-1:0];
  uart_tx #(.DIV(DIV)) u_uart (
    .clk(clk),
    .reset(reset),
    .start(we && io && sel == io_sel(IO_UART_DATA_BIT)),
    .data(bus.memWData[7:0]),
    .tx(uartTx),
    .busy(busy)
  );
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: vector table plus scoreboarded reads and UART frame sequences.
module tb_data_bus_responder;
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  m;
    logic        r;
    logic [31:0] e;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [4:0] leds;
  logic tx;
  logic pend;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  vec_t vt[$];
  data_bus_responder_if bus ();
  data_bus_responder #(
    .RAM_WORDS(16), .RAM_INIT(""), .CLK_FREQ(1000), .BAUD(100), .NUM_LEDS(5)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus), .leds(leds), .uartTx(tx)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                       input logic r, input logic [31:0] e);
    bus.ramAddr = a;
    bus.memWData = d;
    bus.memWMask = m;
    bus.ramRStrb = r;
    if (r) exp_q.push_back(e);
  endtask
  task automatic idle();
    drive(32'h0, 32'h0, 4'h0, 1'b0, 32'h0);
  endtask
  function automatic logic fbit(input logic [7:0] d, input int k);
    int b;
    b = k / 10;
    return b == 0 ? 1'b0 : b == 9 ? 1'b1 : d[b-1];
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) pend <= 1'b0;
    else pend <= bus.ramRStrb;
  always @(negedge clk)
    if (pend) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_underflow: got read data %h with nothing expected", bus.ramRData);
      end else check("rdata", bus.ramRData, exp_q.pop_front());
    end
  initial begin
    idle();
    vt.push_back('{32'h0000_0100, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0});
    vt.push_back('{32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF});
    vt.push_back('{32'h0000_0102, 32'hAAAA_AAAA, 4'b0100, 1'b0, 32'h0});
    vt.push_back('{32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'hDEAA_BEEF});
    vt.push_back('{32'h0000_0100, 32'h1234_1234, 4'b1100, 1'b0, 32'h0});
    vt.push_back('{32'h0000_0100, 32'h0, 4'h0, 1'b1, 32'h1234_BEEF});
    vt.push_back('{32'h0000_0000, 32'h0000_0055, 4'hF, 1'b0, 32'h0});
    vt.push_back('{32'h0000_0040, 32'h0, 4'h0, 1'b1, 32'h0000_0055});
    vt.push_back('{32'h0040_0020, 32'h0, 4'h0, 1'b1, 32'h0});
    vt.push_back('{32'h0040_0000, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0});
    vt.push_back('{32'h0000_0000, 32'h0, 4'h0, 1'b1, 32'h0000_0055});
    vt.push_back('{32'h0040_0008, 32'h0, 4'h0, 1'b1, 32'h0});
    vt.push_back('{32'h0040_0010, 32'h0, 4'h0, 1'b1, 32'h0});
    vt.push_back('{32'h0040_0004, 32'h0000_0003, 4'b0001, 1'b0, 32'h0});
    vt.push_back('{32'h0040_0004, 32'hFFFF_FFFF, 4'h0, 1'b1, 32'h0000_0003});
    vt.push_back('{32'h0000_0000, 32'h7777_7777, 4'hF, 1'b1, 32'h0000_0055});
    vt.push_back('{32'h0000_0000, 32'h0, 4'h0, 1'b1, 32'h7777_7777});
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.ramRData, 32'h0);
    check("reset_leds", 32'(leds), 32'h0);
    check("reset_tx", 32'(tx), 32'h1);
    reset = 1'b0;
    foreach (vt[i]) begin
      @(negedge clk);
      drive(vt[i].a, vt[i].d, vt[i].m, vt[i].r, vt[i].e);
    end
    @(negedge clk);
    idle();
    repeat (3) @(negedge clk);
    check("hold_rdata", bus.ramRData, 32'h7777_7777);
    drive(32'h0040_0004, 32'hFFFF_FFFF, 4'hF, 1'b0, 32'h0);
    @(negedge clk);
    idle();
    check("leds_all", 32'(leds), 32'h1F);
    drive(32'h0040_0004, 32'h0, 4'h0, 1'b1, 32'h0000_001F);
    @(negedge clk);
    idle();
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_leds", 32'(leds), 32'h0);
    check("async_rdata", bus.ramRData, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(32'h0040_0008, 32'h0000_00A5, 4'h1, 1'b0, 32'h0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("frame_a5", 32'(tx), 32'(fbit(8'hA5, k)));
      if (k == 20) drive(32'h0040_0010, 32'h0, 4'h0, 1'b1, 32'h0000_0200);
      else if (k == 49) drive(32'h0040_0008, 32'h0000_003C, 4'h1, 1'b0, 32'h0);
      else idle();
    end
    @(negedge clk);
    drive(32'h0040_0010, 32'h0, 4'h0, 1'b1, 32'h0);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      idle();
      check("idle_after_drop", 32'(tx), 32'h1);
    end
    drive(32'h0040_0008, 32'h0000_003C, 4'h1, 1'b0, 32'h0);
    for (int k = 0; k < 35; k++) begin
      @(negedge clk);
      idle();
      check("frame_3c", 32'(tx), 32'(fbit(8'h3C, k)));
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("mid_reset_tx", 32'(tx), 32'h1);
    check("mid_reset_busy", 32'(dut.busy), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    drive(32'h0040_0008, 32'h0000_005A, 4'h1, 1'b0, 32'h0);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("frame_5a", 32'(tx), 32'(fbit(8'h5A, k)));
      if (k == 99) drive(32'h0040_0008, 32'h0000_00C3, 4'h1, 1'b0, 32'h0);
      else idle();
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      idle();
      check("frame_c3", 32'(tx), 32'(fbit(8'hC3, k)));
    end
    repeat (3) @(negedge clk);
    check("final_tx", 32'(tx), 32'h1);
    check("sb_empty", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
